// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath width, PC step and the
// fetch packet handed from fetch to decode.
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  // One fetched instruction as seen by decode.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

  // Force an address onto an instruction boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry hold register for a fetched word that decode could not take.
// flush beats load beats drain. valid_next is exported so the fetch stage
// can decide this cycle whether a new request would have a landing slot.
module fetch_hold_buf
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       flush,
  input  logic       load,
  input  logic       drain,
  input  fetch_pkt_t load_pkt,
  output fetch_pkt_t hold_pkt,
  output logic       valid_next
);

  logic            hold_valid_reg;
  logic [XLEN-1:0] hold_pc_reg;
  logic [XLEN-1:0] hold_instr_reg;

  // Next occupancy: a flush empties, a load fills (even while draining),
  // a drain without a load empties, otherwise hold what we have.
  always_comb begin
    valid_next = hold_valid_reg;
    if (flush) begin
      valid_next = 1'b0;
    end else if (load) begin
      valid_next = 1'b1;
    end else if (drain) begin
      valid_next = 1'b0;
    end
  end

  // Occupancy and payload registers; payload only changes on a real load.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_valid_reg <= 1'b0;
      hold_pc_reg    <= '0;
      hold_instr_reg <= '0;
    end else begin
      hold_valid_reg <= valid_next;
      if (load && !flush) begin
        hold_pc_reg    <= load_pkt.pc;
        hold_instr_reg <= load_pkt.instr;
      end
    end
  end

  assign hold_pkt = '{valid: hold_valid_reg, pc: hold_pc_reg, instr: hold_instr_reg};

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one aligned read per cycle
// to a 1-cycle-latency instruction RAM, parks an unaccepted word in a
// one-entry hold buffer and presents {pc, instr} to decode.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            resetn,
  output logic [XLEN-1:0] instr_sram_addr,
  output logic            instr_sram_en,
  output logic            instr_sram_we,
  output logic [XLEN-1:0] instr_sram_wdata,
  input  logic [XLEN-1:0] instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
);

  logic [XLEN-1:0] fetch_pc_reg;
  logic            rsp_valid_reg;
  logic [XLEN-1:0] rsp_pc_reg;

  fetch_pkt_t      hold_pkt;
  fetch_pkt_t      rsp_pkt;
  fetch_pkt_t      out_pkt;
  logic            hold_valid_next;
  logic            hold_load;
  logic            fire;
  logic            issue_en;
  logic [XLEN-1:0] issue_addr;

  // The RAM word returning this cycle, tagged with the PC it was read from.
  assign rsp_pkt = '{valid: rsp_valid_reg, pc: rsp_pc_reg, instr: instr};

  // Output mux: the held word is older, so it always goes first. A redirect
  // or reset blanks the output so nothing can be accepted that cycle.
  always_comb begin
    out_pkt = '0;
    if (hold_pkt.valid) begin
      out_pkt = hold_pkt;
    end else if (rsp_valid_reg) begin
      out_pkt = rsp_pkt;
    end
    if (redirect_valid || !resetn) begin
      out_pkt = '0;
    end
  end

  // A response must be captured unless it was the presented word and was
  // taken; with the hold full it is never the presented word.
  always_comb begin
    fire      = out_pkt.valid && id_ready;
    hold_load = rsp_valid_reg && (hold_pkt.valid || !fire);
  end

  fetch_hold_buf u_hold (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (redirect_valid),
    .load       (hold_load),
    .drain      (fire),
    .load_pkt   (rsp_pkt),
    .hold_pkt   (hold_pkt),
    .valid_next (hold_valid_next)
  );

  // Issue only when next cycle's hold slot is free, so every returning word
  // has somewhere to go. A redirect always issues its aligned target.
  always_comb begin
    issue_addr = fetch_pc_reg;
    if (redirect_valid) begin
      issue_addr = align_pc(redirect_pc);
    end
    issue_en = resetn && (redirect_valid || !hold_valid_next);
  end

  // PC and in-flight request tracking; +4 wraps naturally at 2^32.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_reg  <= RESET_PC;
      rsp_valid_reg <= 1'b0;
      rsp_pc_reg    <= '0;
    end else begin
      rsp_valid_reg <= issue_en;
      if (issue_en) begin
        rsp_pc_reg   <= issue_addr;
        fetch_pc_reg <= issue_addr + PC_INC;
      end
    end
  end

  assign instr_sram_en    = issue_en;
  assign instr_sram_addr  = issue_en ? issue_addr : '0;
  assign instr_sram_we    = 1'b0;
  assign instr_sram_wdata = '0;

  assign if_valid = out_pkt.valid;
  assign if_pc    = out_pkt.pc;
  assign if_instr = out_pkt.instr;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: behavioural 1-cycle RAM, per-cycle port checks and
// a scoreboard of PCs expected to be accepted by decode, in order.
module tb_instr_fetch;

  logic        clk;
  logic        resetn;
  logic [31:0] instr_sram_addr;
  logic        instr_sram_en;
  logic        instr_sram_we;
  logic [31:0] instr_sram_wdata;
  logic [31:0] instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .instr_sram_addr  (instr_sram_addr),
    .instr_sram_en    (instr_sram_en),
    .instr_sram_we    (instr_sram_we),
    .instr_sram_wdata (instr_sram_wdata),
    .instr            (instr),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .id_ready         (id_ready),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .if_instr         (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct, address-derived content for every word of the RAM.
  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hC0DE_5A5A;
  endfunction

  // Synchronous-read instruction RAM.
  always @(posedge clk) begin
    if (instr_sram_en) instr <= ram_word(instr_sram_addr);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted word must be the next expected PC with its data.
  always @(negedge clk) begin
    if (resetn && if_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_accept", if_pc, 32'hDEAD_BEEF);
      end else begin
        logic [31:0] pc_e;
        pc_e = exp_q.pop_front();
        check_eq("accept_pc", if_pc, pc_e);
        check_eq("accept_instr", if_instr, ram_word(pc_e));
        $display("accept pc=%08h instr=%08h", if_pc, if_instr);
      end
    end
  end

  // One clock cycle: drive inputs, check ports mid-cycle, advance.
  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc,
                     input logic exp_v, input logic [31:0] exp_pc,
                     input logic exp_en, input logic [31:0] exp_addr,
                     input logic accept);
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (accept) exp_q.push_back(exp_pc);
    @(negedge clk);
    check_eq("if_valid", {31'd0, if_valid}, {31'd0, exp_v});
    if (exp_v) check_eq("if_pc", if_pc, exp_pc);
    check_eq("sram_en", {31'd0, instr_sram_en}, {31'd0, exp_en});
    if (exp_en) check_eq("sram_addr", instr_sram_addr, exp_addr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn         = 1'b0;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_en", {31'd0, instr_sram_en}, 32'd0);
    check_eq("rst_valid", {31'd0, if_valid}, 32'd0);
    check_eq("rst_addr", instr_sram_addr, 32'd0);
    check_eq("rst_pc", if_pc, 32'd0);
    check_eq("rst_instr", if_instr, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Start-up and streaming.
    cyc(1, 0, 0, 0, 32'h0,  1, 32'h0,  0);
    cyc(1, 0, 0, 1, 32'h0,  1, 32'h4,  1);
    cyc(1, 0, 0, 1, 32'h4,  1, 32'h8,  1);
    cyc(1, 0, 0, 1, 32'h8,  1, 32'hC,  1);
    cyc(1, 0, 0, 1, 32'hC,  1, 32'h10, 1);
    cyc(1, 0, 0, 1, 32'h10, 1, 32'h14, 1);
    // Three-cycle stall on 0x14, then zero-bubble restart.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 32'h14, 0, 32'h0, 0);
    cyc(1, 0, 0, 1, 32'h14, 1, 32'h18, 1);
    // Fill hold with 0x18, then redirect to unaligned 0x103.
    cyc(0, 0, 0, 1, 32'h18, 0, 32'h0, 0);
    cyc(1, 1, 32'h103, 0, 32'h0, 1, 32'h100, 0);
    cyc(1, 0, 0, 1, 32'h100, 1, 32'h104, 1);
    cyc(1, 0, 0, 1, 32'h104, 1, 32'h108, 1);
    // Redirect with decode stalled: target lands in hold.
    cyc(0, 1, 32'h200, 0, 32'h0, 1, 32'h200, 0);
    cyc(0, 0, 0, 1, 32'h200, 0, 32'h0, 0);
    cyc(0, 0, 0, 1, 32'h200, 0, 32'h0, 0);
    cyc(1, 0, 0, 1, 32'h200, 1, 32'h204, 1);
    // PC wrap at the top of the address space.
    cyc(1, 1, 32'hFFFF_FFF8, 0, 32'h0, 1, 32'hFFFF_FFF8, 0);
    cyc(1, 0, 0, 1, 32'hFFFF_FFF8, 1, 32'hFFFF_FFFC, 1);
    cyc(1, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'h0, 1);
    cyc(0, 0, 0, 1, 32'h0, 0, 32'h0, 0);
    check_eq("const_we", {31'd0, instr_sram_we}, 32'd0);
    check_eq("const_wdata", instr_sram_wdata, 32'd0);

    // Reset while the hold buffer is full: output drops immediately.
    resetn = 1'b0;
    #1;
    check_eq("midrst_valid", {31'd0, if_valid}, 32'd0);
    check_eq("midrst_en", {31'd0, instr_sram_en}, 32'd0);
    @(posedge clk);
    #1;
    id_ready = 1'b1;
    resetn   = 1'b1;
    cyc(1, 0, 0, 0, 32'h0, 1, 32'h0, 0);
    cyc(1, 0, 0, 1, 32'h0, 1, 32'h4, 1);
    cyc(1, 0, 0, 1, 32'h4, 1, 32'h8, 1);

    check_eq("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of the instruction RAM (four byte-lane BRAMs with 1-cycle synchronous read). Owns the PC: issues one word-aligned read per cycle and absorbs the RAM's read latency. A one-entry hold buffer lets decode back-pressure without losing an in-flight word. Takes branch/jump redirects from execute and presents `{pc, instr}` to decode with a valid/ready handshake.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; must be 4-byte aligned.
- `clk`  in  1  single clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `instr_sram_addr`  out  32  byte address to the instruction RAM; RAM uses bits [31:2].
- `instr_sram_en`  out  1  read enable; one request per cycle when high.
- `instr_sram_we`  out  1  constant 0.
- `instr_sram_wdata`  out  32  constant 0.
- `instr`  in  32  RAM read data; valid the cycle after `instr_sram_en`.
- `redirect_valid`  in  1  one-cycle pulse: restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  redirect target; bits [1:0] are forced to 0.
- `id_ready`  in  1  decode accepts the presented instruction this cycle.
- `if_valid`  out  1  `if_pc`/`if_instr` are valid.
- `if_pc`  out  32  PC of the presented instruction.
- `if_instr`  out  32  presented instruction word.

## Operation
- State: `fetch_pc` (next address), `rsp_valid`/`rsp_pc` (request issued last cycle, data now on `instr`), `hold_valid`/`hold_pc`/`hold_instr` (buffered word).
- Output mux: if `hold_valid`, present the hold buffer. Else if `rsp_valid`, present `{rsp_pc, instr}` straight from the RAM. Else `if_valid`=0.
- Fire = `if_valid && id_ready`.
- Next `hold_valid` = (hold_valid && !fire) || (hold_valid && fire && rsp_valid) || (!hold_valid && rsp_valid && !fire).
  - Hold loads `{rsp_pc, instr}` whenever a response is valid but was not the presented word, or was presented but not accepted.
- Issue rule: `instr_sram_en`=1 iff next `hold_valid`=0. This guarantees a returning word always has a slot.
- On issue: `instr_sram_addr`=`fetch_pc`, `rsp_pc`<=`fetch_pc`, `fetch_pc`<=`fetch_pc`+4. The +4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Redirect has priority over everything else:
  - In the redirect cycle, `if_valid` is forced to 0, so no fire occurs.
  - `hold_valid` and `rsp_valid` are both treated as cleared.
  - `instr_sram_en`=1 and `instr_sram_addr`=`redirect_pc` & ~3 are driven in the same cycle.
  - `fetch_pc`<=`redirect_pc`+4 and `rsp_valid`<=1.
- Reset (async, `resetn`=0):
  - Registers: `fetch_pc`=RESET_PC, `rsp_valid`=0, `hold_valid`=0, `hold_pc`=0, `hold_instr`=0.
  - Outputs: `instr_sram_en`=0, `if_valid`=0, `if_pc`=0, `if_instr`=0, `instr_sram_addr`=0.
- Reset asserted mid-operation discards any in-flight request and held word immediately. No stale word may surface after release.

## Timing
- Fetch latency: issue in cycle N, word presented in cycle N+1 (`if_valid`=1, `if_pc`=issued address).
- After `resetn` rises, the first rising edge issues RESET_PC. First `if_valid` comes one cycle later.
- Steady state with `id_ready`=1: one instruction per cycle, PCs strictly +4.
- `id_ready` low for K cycles:
  - The word in flight lands in the hold buffer.
  - `instr_sram_en`=0 for those K cycles.
  - Output stays stable; no word is dropped or duplicated.
- Restart after stall: the same cycle `id_ready` rises, hold drains and a new request issues. Zero bubbles.
- Redirect penalty: exactly one bubble cycle (the redirect cycle). The target is presented in the next cycle.
- `redirect_valid` and `id_ready`=0 in the same cycle: the redirect still wins. The target is fetched and then held.
- Combinational paths `id_ready` → `instr_sram_en` and `redirect_*` → `instr_sram_addr` are permitted. The `instr` → `if_instr` path is combinational.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN` = 32.
  - `INSTR_BYTES` = 4.
  - `PC_INC` = 32'd4.
  - A `fetch_pkt_t` struct {valid, pc[31:0], instr[31:0]}, reused by decode.
- Sub-module `fetch_hold_buf`: the one-entry hold register with load/drain/flush controls. It is instantiated once. The top level keeps the PC, issue logic and output mux.

## Test plan
- Reset release, `id_ready`=1 → `instr_sram_en`=1 and addr=RESET_PC in cycle 0. Cycles 1..4 present PCs 0x0, 0x4, 0x8, 0xC with the matching RAM words.
- `id_ready` low for 3 cycles while word at 0x8 is in flight → `if_pc`=0x8 held stable and `instr_sram_en`=0 for those cycles. On release, 0x8 is accepted and 0xC is presented next cycle; no PC is skipped or repeated.
- `redirect_valid` pulse with `redirect_pc`=0x103 while hold is full → same cycle `if_valid`=0 and addr=0x100. Next cycle `if_pc`=0x100, then 0x104.
- Redirect and `id_ready`=0 together → target 0x200 is fetched into hold. `if_pc`=0x200 persists until `id_ready`=1.
- `fetch_pc` at 0xFFFF_FFFC → next issued address is 0x0000_0000.
- `resetn` pulsed low with hold full and a response in flight → `if_valid`=0 immediately. After release, the fetch sequence restarts at RESET_PC with no stale word.
